// File: rtl/lock_pkg.sv
// Shared keypad codes, FSM state encoding and key classification for the lock controller.
package lock_pkg;

  localparam logic [3:0] KEY_HASH = 4'd10;
  localparam logic [3:0] KEY_STAR = 4'd11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  function automatic logic key_is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; expire flags the final cycle so a load of N gives N cycles.
module lock_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: digit entry, password check, timed unlock and retry lockout.
// Define LOCK_PWCHG_EN to allow a new password to be entered while unlocked.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned         PW_LEN      = 4,
  parameter logic [4*PW_LEN-1:0] DEF_PW      = 16'h1234,
  parameter int unsigned         MAX_TRIES   = 3,
  parameter int unsigned         OPEN_CYC    = 500,
  parameter int unsigned         LOCKOUT_CYC = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       unlock,
  output logic       alarm,
  output logic       err,
  output logic [2:0] digit_cnt,
  output logic       pw_changed
);

  localparam int unsigned BW      = 4 * PW_LEN;
  localparam int unsigned CYC_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int unsigned TW      = $clog2(CYC_MAX + 1);
  localparam int unsigned FW      = $clog2(MAX_TRIES + 1);
  localparam logic [2:0]  CNT_FULL = 3'(PW_LEN);
  localparam logic [2:0]  CNT_OVF  = (PW_LEN >= 7) ? 3'd7 : 3'(PW_LEN + 1);

  state_e          state, state_next;
  logic            key_valid_d;
  logic [BW-1:0]   buffer, buffer_nxt, password;
  logic [2:0]      cnt_nxt;
  logic            ovf, ovf_nxt;
  logic [FW-1:0]   fail_cnt, fail_nxt;
  logic            timer_load, timer_expire;
  logic [TW-1:0]   timer_val;
  logic            unlock_nxt, alarm_nxt, err_nxt;

  // One event per press, however long key_valid is held
  logic key_evt, dig_evt, hash_evt, star_evt;
  assign key_evt  = key_valid & ~key_valid_d;
  assign dig_evt  = key_evt & key_is_digit(key_code);
  assign hash_evt = key_evt & (key_code == KEY_HASH);
  assign star_evt = key_evt & (key_code == KEY_STAR);

  // Digit append; once full the buffer freezes and the overflow flag spoils the entry
  logic            room, pw_full, match;
  logic [BW-1:0]   app_buffer;
  logic [2:0]      app_cnt;
  assign room       = (digit_cnt < CNT_FULL);
  assign app_buffer = room ? BW'({buffer, key_code}) : buffer;
  assign app_cnt    = room ? (digit_cnt + 3'd1) : CNT_OVF;
  assign pw_full    = (digit_cnt == CNT_FULL) && !ovf;
  assign match      = pw_full && (buffer == password);

  lock_timer #(.W(TW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (timer_load),
    .value  (timer_val),
    .expire (timer_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dig_evt) state_next = ENTRY;
      ENTRY: begin
        if (star_evt)      state_next = IDLE;
        else if (hash_evt) state_next = CHECK;
      end
      CHECK: begin
        if (match)                                state_next = OPEN;
        else if (fail_cnt >= FW'(MAX_TRIES - 1))  state_next = LOCKOUT;
        else                                      state_next = IDLE;
      end
      OPEN: begin
        if (timer_expire || star_evt) state_next = IDLE;
`ifdef LOCK_PWCHG_EN
        else if (hash_evt && pw_full) state_next = IDLE;
`endif
      end
      LOCKOUT: if (timer_expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef LOCK_PWCHG_EN
  logic [BW-1:0] password_nxt;
  logic          pwchg_nxt;
`endif

  always_comb begin
    buffer_nxt = buffer;
    cnt_nxt    = digit_cnt;
    ovf_nxt    = ovf;
    fail_nxt   = fail_cnt;
    timer_load = 1'b0;
    timer_val  = '0;
    unlock_nxt = (state_next == OPEN);
    alarm_nxt  = (state_next == LOCKOUT);
    err_nxt    = 1'b0;
`ifdef LOCK_PWCHG_EN
    password_nxt = password;
    pwchg_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (dig_evt) begin
          buffer_nxt = BW'(key_code);
          cnt_nxt    = 3'd1;
          ovf_nxt    = 1'b0;
        end
      end
      ENTRY: begin
        if (star_evt) begin
          buffer_nxt = '0;
          cnt_nxt    = '0;
          ovf_nxt    = 1'b0;
        end else if (dig_evt) begin
          buffer_nxt = app_buffer;
          cnt_nxt    = app_cnt;
          ovf_nxt    = ~room;
        end
      end
      CHECK: begin
        buffer_nxt = '0;
        cnt_nxt    = '0;
        ovf_nxt    = 1'b0;
        timer_load = 1'b1;
        if (match) begin
          fail_nxt  = '0;
          timer_val = TW'(OPEN_CYC);
        end else begin
          err_nxt   = 1'b1;
          fail_nxt  = FW'(fail_cnt + FW'(1));
          timer_val = TW'(LOCKOUT_CYC);
          timer_load = (state_next == LOCKOUT);
        end
      end
      OPEN: begin
`ifdef LOCK_PWCHG_EN
        if (dig_evt) begin
          buffer_nxt = app_buffer;
          cnt_nxt    = app_cnt;
          ovf_nxt    = ~room;
        end else if (hash_evt) begin
          if (pw_full) begin
            password_nxt = buffer;
            pwchg_nxt    = 1'b1;
          end
          buffer_nxt = '0;
          cnt_nxt    = '0;
          ovf_nxt    = 1'b0;
        end
`endif
        if (state_next == IDLE) begin
          buffer_nxt = '0;
          cnt_nxt    = '0;
          ovf_nxt    = 1'b0;
        end
      end
      LOCKOUT: if (timer_expire) fail_nxt = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_valid_d <= 1'b0;
      buffer      <= '0;
      digit_cnt   <= '0;
      ovf         <= 1'b0;
      fail_cnt    <= '0;
      unlock      <= 1'b0;
      alarm       <= 1'b0;
      err         <= 1'b0;
    end else begin
      key_valid_d <= key_valid;
      buffer      <= buffer_nxt;
      digit_cnt   <= cnt_nxt;
      ovf         <= ovf_nxt;
      fail_cnt    <= fail_nxt;
      unlock      <= unlock_nxt;
      alarm       <= alarm_nxt;
      err         <= err_nxt;
    end
  end

`ifdef LOCK_PWCHG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      password   <= DEF_PW;
      pw_changed <= 1'b0;
    end else begin
      password   <= password_nxt;
      pw_changed <= pwchg_nxt;
    end
  end
`else
  assign password   = DEF_PW;
  assign pw_changed = 1'b0;
`endif

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl; covers the LOCK_PWCHG_EN build when that macro is defined.
module tb_lock_ctrl;
  import lock_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_valid = 1'b0;
  logic       unlock, alarm, err, pw_changed;
  logic [2:0] digit_cnt;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0, unlock_cyc = 0, alarm_cyc = 0, pwchg_cnt = 0;
  int e0, a0, u0, p0;

  always #5 clock = ~clock;

  lock_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .unlock     (unlock),
    .alarm      (alarm),
    .err        (err),
    .digit_cnt  (digit_cnt),
    .pw_changed (pw_changed)
  );

  // Running tallies of output activity, sampled mid-cycle
  always @(negedge clock) begin
    if (err)        err_cnt++;
    if (unlock)     unlock_cyc++;
    if (alarm)      alarm_cyc++;
    if (pw_changed) pwchg_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    @(negedge clock);
    key_code  = code;
    key_valid = 1'b1;
    repeat (hold) @(negedge clock);
    key_valid = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Nibbles of keys are pressed most-significant first
  task automatic enter(input logic [31:0] keys, input int n);
    for (int i = n - 1; i >= 0; i--) press(keys[4*i +: 4], 1);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_eq("rst_unlock", 32'(unlock), 0);
    check_eq("rst_alarm", 32'(alarm), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_digits", 32'(digit_cnt), 0);
    check_eq("rst_pwchg", 32'(pw_changed), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Correct code opens for exactly OPEN_CYC cycles
    e0 = err_cnt; u0 = unlock_cyc;
    enter(32'h123, 3);
    check_eq("entry_digits3", 32'(digit_cnt), 3);
    enter(32'h4A, 2);
    check_eq("open_unlock", 32'(unlock), 1);
    check_eq("open_digits", 32'(digit_cnt), 0);
    repeat (600) @(negedge clock);
    check_eq("open_len", 32'(unlock_cyc - u0), 500);
    check_eq("open_no_err", 32'(err_cnt - e0), 0);
    check_eq("open_relock", 32'(unlock), 0);

    // Three wrong codes lock out; keys ignored while locked
    e0 = err_cnt; a0 = alarm_cyc;
    enter(32'h1235A, 5);
    enter(32'h1235A, 5);
    check_eq("two_wrong_err", 32'(err_cnt - e0), 2);
    check_eq("two_wrong_noalarm", 32'(alarm), 0);
    enter(32'h1235A, 5);
    check_eq("lock_alarm", 32'(alarm), 1);
    check_eq("lock_err", 32'(err_cnt - e0), 3);
    enter(32'h1234A, 5);
    check_eq("lock_ignore_unlock", 32'(unlock), 0);
    check_eq("lock_ignore_digits", 32'(digit_cnt), 0);
    repeat (1100) @(negedge clock);
    check_eq("lock_len", 32'(alarm_cyc - a0), 1000);
    check_eq("lock_err_total", 32'(err_cnt - e0), 3);
    check_eq("lock_end_alarm", 32'(alarm), 0);
    enter(32'h1234A, 5);
    check_eq("post_lock_unlock", 32'(unlock), 1);
    press(KEY_STAR, 1);
    check_eq("star_relock", 32'(unlock), 0);

    // Overflow with long key holds: one digit per press, entry rejected
    e0 = err_cnt;
    press(4'd1, 10);
    check_eq("hold_one_digit", 32'(digit_cnt), 1);
    for (int d = 2; d <= 5; d++) press(4'(d), 10);
    check_eq("ovf_digits", 32'(digit_cnt), 5);
    press(KEY_HASH, 10);
    check_eq("ovf_err", 32'(err_cnt - e0), 1);
    check_eq("ovf_no_unlock", 32'(unlock), 0);
    check_eq("ovf_cleared", 32'(digit_cnt), 0);

    // fail_cnt is 1 here; one more miss makes 2, and '*' must not add a third
    e0 = err_cnt;
    enter(32'h9999A, 5);
    enter(32'h12B, 3);
    check_eq("star_clear", 32'(digit_cnt), 0);
    check_eq("star_no_err", 32'(err_cnt - e0), 1);
    enter(32'h1234A, 5);
    check_eq("star_then_unlock", 32'(unlock), 1);
    check_eq("star_then_noalarm", 32'(alarm), 0);
    press(KEY_STAR, 1);
    enter(32'h1111A, 5);
    enter(32'h1111A, 5);
    check_eq("match_clears_fail", 32'(alarm), 0);
    enter(32'h1234A, 5);
    press(KEY_STAR, 1);

    // Reserved codes and stray '#'/'*' in IDLE do nothing
    e0 = err_cnt;
    press(4'd12, 1);
    press(4'd15, 1);
    press(KEY_HASH, 1);
    press(KEY_STAR, 1);
    check_eq("idle_ignore_digits", 32'(digit_cnt), 0);
    check_eq("idle_ignore_err", 32'(err_cnt - e0), 0);
    check_eq("idle_ignore_unlock", 32'(unlock), 0);

`ifdef LOCK_PWCHG_EN
    e0 = err_cnt; p0 = pwchg_cnt;
    enter(32'h1234A, 5);
    enter(32'h9876A, 5);
    check_eq("pwchg_pulse", 32'(pwchg_cnt - p0), 1);
    check_eq("pwchg_idle", 32'(unlock), 0);
    enter(32'h1234A, 5);
    check_eq("old_pw_err", 32'(err_cnt - e0), 1);
    enter(32'h9876A, 5);
    check_eq("new_pw_unlock", 32'(unlock), 1);
`else
    p0 = pwchg_cnt;
    enter(32'h1234A, 5);
    enter(32'h9876A, 5);
    check_eq("open_digits_ignored", 32'(digit_cnt), 0);
    check_eq("open_hash_ignored", 32'(unlock), 1);
    check_eq("no_pwchg", 32'(pwchg_cnt - p0), 0);
    press(KEY_STAR, 1);
    enter(32'h1234A, 5);
    check_eq("pw_unchanged", 32'(unlock), 1);
`endif

    // Reset mid-OPEN clears outputs at once and restores the default password
    repeat (20) @(negedge clock);
    pulse_reset();
    check_eq("rst_open_unlock", 32'(unlock), 0);
    check_eq("rst_open_digits", 32'(digit_cnt), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    enter(32'h1234A, 5);
    check_eq("rst_def_pw", 32'(unlock), 1);
    press(KEY_STAR, 1);

    // Reset mid-LOCKOUT
    enter(32'h1235A, 5);
    enter(32'h1235A, 5);
    enter(32'h1235A, 5);
    check_eq("lock2_alarm", 32'(alarm), 1);
    repeat (50) @(negedge clock);
    pulse_reset();
    check_eq("rst_lock_alarm", 32'(alarm), 0);
    check_eq("rst_lock_err", 32'(err), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    e0 = err_cnt;
    enter(32'h1234A, 5);
    check_eq("rst_lock_unlock", 32'(unlock), 1);
    check_eq("rst_lock_no_err", 32'(err_cnt - e0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
